// File: rtl/adder_error_monitor.sv
// Error-metric monitor for approximate 16-bit adders: recomputes the exact sum and
// accumulates error rate, max and summed error distance. Optional: ADDER_MON_FIRST_ERR_EN.
module adder_error_monitor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] error_count,
    output logic [WIDTH:0]   max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_cin,
    output logic [CNT_W-1:0] first_err_idx
);
    localparam int unsigned RW    = WIDTH + 1;
    localparam int unsigned SUM_W = ((ACC_W > RW) ? ACC_W : RW) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d, acc_q, acc_d;
    logic             in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic             s1_cin_q, s1_cin_d, s2_cin_q, s2_cin_d;
    logic [RW-1:0]    s1_approx_q, s1_approx_d, s2_approx_q, s2_approx_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d, error_count_q, error_count_d;
    logic [RW-1:0]    max_ed_q, max_ed_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;

    logic             xfer;
    logic [RW-1:0]    exact, ed;
    logic [SUM_W-1:0] sum_ext;

    // Next-state, pipeline and statistics update
    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        acc_d          = acc_q;
        s1_valid_d     = 1'b0;
        s1_a_d         = s1_a_q;
        s1_b_d         = s1_b_q;
        s1_cin_d       = s1_cin_q;
        s1_approx_d    = s1_approx_q;
        s2_valid_d     = s1_valid_q;
        s2_a_d         = s1_a_q;
        s2_b_d         = s1_b_q;
        s2_cin_d       = s1_cin_q;
        s2_approx_d    = s1_approx_q;
        sample_count_d = sample_count_q;
        error_count_d  = error_count_q;
        max_ed_d       = max_ed_q;
        sum_ed_d       = sum_ed_q;

        xfer = in_valid && in_ready_q && !start;
        if (xfer) begin
            s1_valid_d  = 1'b1;
            s1_a_d      = a;
            s1_b_d      = b;
            s1_cin_d    = cin;
            s1_approx_d = {dut_cout, dut_sum};
        end

        exact   = RW'(s2_a_q) + RW'(s2_b_q) + RW'(s2_cin_q);
        ed      = (exact >= s2_approx_q) ? (exact - s2_approx_q) : (s2_approx_q - exact);
        sum_ext = SUM_W'(sum_ed_q) + SUM_W'(ed);

        if (s2_valid_q) begin
            if (sample_count_q != CNT_MAX) sample_count_d = sample_count_q + CNT_W'(1);
            if (ed != '0 && error_count_q != CNT_MAX) error_count_d = error_count_q + CNT_W'(1);
            if (ed > max_ed_q) max_ed_d = ed;
            sum_ed_d = (sum_ext > SUM_W'(ACC_MAX)) ? ACC_MAX : ACC_W'(sum_ext);
        end

        case (state_q)
            RUN: begin
                if (xfer) acc_d = acc_q + CNT_W'(1);
                if (acc_d >= num_q) state_d = DRAIN;
            end
            DRAIN:   if (!s1_valid_q && !s2_valid_q) state_d = DONE;
            default: ;
        endcase

        // Restart wins over everything, including a same-cycle transfer and in-flight samples
        if (start) begin
            state_d        = RUN;
            num_d          = num_samples;
            acc_d          = '0;
            s1_valid_d     = 1'b0;
            s2_valid_d     = 1'b0;
            sample_count_d = '0;
            error_count_d  = '0;
            max_ed_d       = '0;
            sum_ed_d       = '0;
        end

        in_ready_d = (state_d == RUN) && (acc_d < num_d);
        busy_d     = (state_d == RUN) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            num_q          <= '0;
            acc_q          <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_cin_q       <= 1'b0;
            s1_approx_q    <= '0;
            s2_valid_q     <= 1'b0;
            s2_a_q         <= '0;
            s2_b_q         <= '0;
            s2_cin_q       <= 1'b0;
            s2_approx_q    <= '0;
            sample_count_q <= '0;
            error_count_q  <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            acc_q          <= acc_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            s1_valid_q     <= s1_valid_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_cin_q       <= s1_cin_d;
            s1_approx_q    <= s1_approx_d;
            s2_valid_q     <= s2_valid_d;
            s2_a_q         <= s2_a_d;
            s2_b_q         <= s2_b_d;
            s2_cin_q       <= s2_cin_d;
            s2_approx_q    <= s2_approx_d;
            sample_count_q <= sample_count_d;
            error_count_q  <= error_count_d;
            max_ed_q       <= max_ed_d;
            sum_ed_q       <= sum_ed_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = sample_count_q;
    assign error_count  = error_count_q;
    assign max_ed       = max_ed_q;
    assign sum_ed       = sum_ed_q;

`ifdef ADDER_MON_FIRST_ERR_EN
    logic             fe_valid_q, fe_valid_d, fe_cin_q, fe_cin_d;
    logic [WIDTH-1:0] fe_a_q, fe_a_d, fe_b_q, fe_b_d;
    logic [CNT_W-1:0] fe_idx_q, fe_idx_d;

    // Capture the first erroneous sample of a run; its index is the pre-update sample count
    always_comb begin
        fe_valid_d = fe_valid_q;
        fe_a_d     = fe_a_q;
        fe_b_d     = fe_b_q;
        fe_cin_d   = fe_cin_q;
        fe_idx_d   = fe_idx_q;
        if (start) begin
            fe_valid_d = 1'b0;
            fe_a_d     = '0;
            fe_b_d     = '0;
            fe_cin_d   = 1'b0;
            fe_idx_d   = '0;
        end else if (s2_valid_q && ed != '0 && !fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_a_d     = s2_a_q;
            fe_b_d     = s2_b_q;
            fe_cin_d   = s2_cin_q;
            fe_idx_d   = sample_count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_valid_q <= 1'b0;
            fe_a_q     <= '0;
            fe_b_q     <= '0;
            fe_cin_q   <= 1'b0;
            fe_idx_q   <= '0;
        end else begin
            fe_valid_q <= fe_valid_d;
            fe_a_q     <= fe_a_d;
            fe_b_q     <= fe_b_d;
            fe_cin_q   <= fe_cin_d;
            fe_idx_q   <= fe_idx_d;
        end
    end

    assign first_err_valid = fe_valid_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;
    assign first_err_cin   = fe_cin_q;
    assign first_err_idx   = fe_idx_q;
`else
    assign first_err_valid = 1'b0;
    assign first_err_a     = '0;
    assign first_err_b     = '0;
    assign first_err_cin   = 1'b0;
    assign first_err_idx   = '0;
`endif

endmodule
